// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port 2K x 16 data memory between the fetch stage
// (read-only) and the memory stage (read/write). Each granted transaction
// drives the memory port for LATENCY cycles, then pulses the owner's valid
// with its read data. The memory stage wins by default because it holds the
// older instruction.
//
// Build option:
//   ARB_FAIRNESS_EN  - compiles in a 3-bit fetch wait counter. After MAX_WAIT
//                      consecutive losses to the memory stage, fetch is
//                      forced to win the next contested arbitration.
//                      Undefined: strict memory-stage priority.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch read request, held until if_valid
//   if_rdata/if_valid        fetch read data and one-cycle completion pulse
//   mem_req/we/addr/wdata    memory-stage request, held until mem_valid
//   mem_rdata/mem_valid      memory-stage read data and completion pulse
//   stall_if, stall_mem      per-stage stalls (req & ~valid)
//   ram_en/we/addr/wdata     registered memory port controls
//   ram_rdata                memory read data, sampled on last access cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int LATENCY  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q;
  logic [2:0] cnt_q, cnt_d;
  logic       grant_mem, grant_if, last_beat;

`ifdef ARB_FAIRNESS_EN
  logic [2:0] wait_q, wait_d;
  logic       fetch_forced;

  assign fetch_forced = (wait_q == 3'(MAX_WAIT));
`endif

  // Stalls use only the live requests and the registered valids, so there is
  // no combinational path from the memory read data.
  assign stall_if  = if_req  & ~if_valid;
  assign stall_mem = mem_req & ~mem_valid;

  // Next-state, arbitration and access counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    last_beat = 1'b0;
`ifdef ARB_FAIRNESS_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
`ifdef ARB_FAIRNESS_EN
          if (if_req && (!mem_req || fetch_forced)) grant_if = 1'b1;
          else                                       grant_mem = 1'b1;
          // Count only contested losses; any fetch grant clears the count.
          if (grant_if)    wait_d = '0;
          else if (if_req) wait_d = wait_q + 3'd1;
`else
          grant_mem = mem_req;
          grant_if  = ~mem_req;
`endif
          cnt_d   = 3'(LATENCY);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          last_beat = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_FAIRNESS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`endif

  // Memory port and return-data registers. Grants occur only in IDLE and the
  // last beat only in ACCESS, so the two branches never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IF;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_valid <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if (grant_mem || grant_if) begin
        owner_q  <= grant_mem ? OWN_MEM : OWN_IF;
        ram_en   <= 1'b1;
        ram_we   <= grant_mem & mem_we;
        ram_addr <= grant_mem ? mem_addr : if_addr;
        if (grant_mem) ram_wdata <= mem_wdata;
      end else if (last_beat) begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
        if (owner_q == OWN_MEM) begin
          mem_valid <= 1'b1;
          // A write completes without disturbing the previous read data.
          if (!ram_we) mem_rdata <= ram_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with LATENCY = 2, MAX_WAIT = 3. A
// per-cycle vector table covers a single fetch, a write followed by a
// back-to-back read, and simultaneous requests. Hand-written sequences cover
// reset mid-access and continuous contention (grant order depends on
// ARB_FAIRNESS_EN). The memory array is a small behavioural model with
// combinational read and clocked write.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              stall_if;
  logic              stall_mem;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (2),
    .MAX_WAIT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2K x 16 array.
  logic [DATA_W-1:0] ram [0:2047];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              if_valid;
    logic              mem_valid;
    logic              stall_if;
    logic              stall_mem;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] mem_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [10:0] ia, input logic mr, input logic mw,
    input logic [10:0] ma, input logic [15:0] md,
    input logic re, input logic rw, input logic [10:0] ra, input logic [15:0] rd,
    input logic iv, input logic mv, input logic si, input logic sm,
    input logic [15:0] ird, input logic [15:0] mrd);
    vec_t v;
    v.if_req = ir;   v.if_addr = ia;   v.mem_req = mr;    v.mem_we = mw;
    v.mem_addr = ma; v.mem_wdata = md; v.ram_en = re;     v.ram_we = rw;
    v.ram_addr = ra; v.ram_wdata = rd; v.if_valid = iv;   v.mem_valid = mv;
    v.stall_if = si; v.stall_mem = sm; v.if_rdata = ird;  v.mem_rdata = mrd;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic drive(input vec_t v);
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    mem_req   = v.mem_req;
    mem_we    = v.mem_we;
    mem_addr  = v.mem_addr;
    mem_wdata = v.mem_wdata;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] <= 16'(i) ^ 16'hA5A5;
    ram[11'h010] <= 16'h1234;
    ram[11'h020] <= 16'hBEEF;
    ram[2045]    <= 16'hFFFF;
  end

  initial begin
    int          done_n;
    int          bad_data;
    int          leak;
    logic [7:0]  order;

    // Rows are successive cycles: inputs applied, then outputs compared.
    //            ir ia      mr mw ma      md       re rw ra      rd      iv mv si sm ird       mrd
    vecs[0]  = mk(1, 11'h010, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 11'h010, 0, 0, 11'h000, 16'h0, 1, 0, 11'h010, 16'h0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 11'h010, 0, 0, 11'h000, 16'h0, 1, 0, 11'h010, 16'h0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    vecs[3]  = mk(0, 11'h000, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 1, 0, 0, 0, 16'h1234, 16'h0000);
    vecs[4]  = mk(0, 11'h000, 1, 1, 11'd2045, 16'h2, 0, 0, 11'h000, 16'h0, 0, 0, 0, 1, 16'h1234, 16'h0000);
    vecs[5]  = mk(0, 11'h000, 1, 1, 11'd2045, 16'h2, 1, 1, 11'd2045, 16'h2, 0, 0, 0, 1, 16'h1234, 16'h0000);
    vecs[6]  = mk(0, 11'h000, 1, 1, 11'd2045, 16'h2, 1, 1, 11'd2045, 16'h2, 0, 0, 0, 1, 16'h1234, 16'h0000);
    vecs[7]  = mk(0, 11'h000, 1, 0, 11'd2045, 16'h2, 0, 0, 11'h000, 16'h0, 0, 1, 0, 0, 16'h1234, 16'h0000);
    vecs[8]  = mk(0, 11'h000, 1, 0, 11'd2045, 16'h2, 1, 0, 11'd2045, 16'h0, 0, 0, 0, 1, 16'h1234, 16'h0000);
    vecs[9]  = mk(0, 11'h000, 1, 0, 11'd2045, 16'h2, 1, 0, 11'd2045, 16'h0, 0, 0, 0, 1, 16'h1234, 16'h0000);
    vecs[10] = mk(0, 11'h000, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 0, 1, 0, 0, 16'h1234, 16'h0002);
    vecs[11] = mk(1, 11'h020, 1, 0, 11'h010, 16'h0, 0, 0, 11'h000, 16'h0, 0, 0, 1, 1, 16'h1234, 16'h0002);
    vecs[12] = mk(1, 11'h020, 1, 0, 11'h010, 16'h0, 1, 0, 11'h010, 16'h0, 0, 0, 1, 1, 16'h1234, 16'h0002);
    vecs[13] = mk(1, 11'h020, 1, 0, 11'h010, 16'h0, 1, 0, 11'h010, 16'h0, 0, 0, 1, 1, 16'h1234, 16'h0002);
    vecs[14] = mk(1, 11'h020, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 0, 1, 1, 0, 16'h1234, 16'h1234);
    vecs[15] = mk(1, 11'h020, 0, 0, 11'h000, 16'h0, 1, 0, 11'h020, 16'h0, 0, 0, 1, 0, 16'h1234, 16'h1234);
    vecs[16] = mk(1, 11'h020, 0, 0, 11'h000, 16'h0, 1, 0, 11'h020, 16'h0, 0, 0, 1, 0, 16'h1234, 16'h1234);
    vecs[17] = mk(0, 11'h000, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 1, 0, 0, 0, 16'hBEEF, 16'h1234);
    vecs[18] = mk(0, 11'h000, 0, 0, 11'h000, 16'h0, 0, 0, 11'h000, 16'h0, 0, 0, 0, 0, 16'hBEEF, 16'h1234);

    // ---------------- reset values ----------------
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_en",    32'(ram_en),    0);
    check("rst_ram_we",    32'(ram_we),    0);
    check("rst_ram_addr",  32'(ram_addr),  0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_valids",    32'({if_valid, mem_valid}), 0);
    check("rst_rdata",     32'({if_rdata, mem_rdata}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table-driven cycles ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ram_en", i),    32'(ram_en),    32'(vecs[i].ram_en));
      check($sformatf("v%0d_ram_we", i),    32'(ram_we),    32'(vecs[i].ram_we));
      check($sformatf("v%0d_if_valid", i),  32'(if_valid),  32'(vecs[i].if_valid));
      check($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].mem_valid));
      check($sformatf("v%0d_stall_if", i),  32'(stall_if),  32'(vecs[i].stall_if));
      check($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].stall_mem));
      check($sformatf("v%0d_if_rdata", i),  32'(if_rdata),  32'(vecs[i].if_rdata));
      check($sformatf("v%0d_mem_rdata", i), 32'(mem_rdata), 32'(vecs[i].mem_rdata));
      if (vecs[i].ram_en)
        check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].ram_addr));
      if (vecs[i].ram_we)
        check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].ram_wdata));
      @(posedge clk);
      #1;
    end

    // ---------------- reset mid-access ----------------
    drive(mk(0, 0, 1, 1, 11'h005, 16'h7777, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("mid_ram_en_before", 32'(ram_en), 1);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("mid_ram_en",   32'(ram_en),   0);
    check("mid_ram_we",   32'(ram_we),   0);
    check("mid_ram_addr", 32'(ram_addr), 0);
    check("mid_rdata",    32'({if_rdata, mem_rdata}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    leak = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (if_valid || mem_valid || ram_en) leak++;
    end
    check("mid_no_valid_after", 32'(leak), 0);

    // ---------------- continuous contention ----------------
    if_req = 1'b1; if_addr = 11'h020;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 11'h010; mem_wdata = 16'h0;
    done_n = 0;
    bad_data = 0;
    order = '0;
    for (int c = 0; c < 60 && done_n < 8; c++) begin
      @(posedge clk);
      #1;
      if (if_valid) begin
        order[done_n] = 1'b1;
        if (if_rdata !== 16'hBEEF) bad_data++;
        done_n++;
      end else if (mem_valid) begin
        if (mem_rdata !== 16'h1234) bad_data++;
        done_n++;
      end
    end
    check("contend_completions", 32'(done_n), 8);
    check("contend_data", 32'(bad_data), 0);
`ifdef ARB_FAIRNESS_EN
    // mem, mem, mem, if, mem, mem, mem, if
    check("contend_order_fair", 32'(order), 32'h88);
`else
    check("contend_order_strict", 32'(order), 32'h00);
`endif
    if_req = 1'b0;
    mem_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
